// File: rtl/reg_scoreboard.sv
// Dual-issue register scoreboard: counts long-latency writers per register
// and gates in-order issue of the a/b decode pair against pending results.
module reg_scoreboard (
    input  logic        clk,
    input  logic        rstn,
    input  logic        ID_valid_a,
    input  logic [4:0]  ID_rf_raddr_a1,
    input  logic [4:0]  ID_rf_raddr_a2,
    input  logic        ID_rf_re_a1,
    input  logic        ID_rf_re_a2,
    input  logic [4:0]  ID_rf_waddr_a,
    input  logic        ID_rf_we_a,
    input  logic        ID_long_a,
    input  logic        ID_valid_b,
    input  logic [4:0]  ID_rf_raddr_b1,
    input  logic [4:0]  ID_rf_raddr_b2,
    input  logic        ID_rf_re_b1,
    input  logic        ID_rf_re_b2,
    input  logic [4:0]  ID_rf_waddr_b,
    input  logic        ID_rf_we_b,
    input  logic        ID_long_b,
    input  logic        EX_ready,
    input  logic        flush,
    input  logic        EX_valid_a,
    input  logic        EX_rf_we_a,
    input  logic        EX_long_a,
    input  logic [4:0]  EX_rf_waddr_a,
    input  logic        EX_valid_b,
    input  logic        EX_rf_we_b,
    input  logic        EX_long_b,
    input  logic [4:0]  EX_rf_waddr_b,
    input  logic        WB_rf_we_a,
    input  logic        WB_long_a,
    input  logic [4:0]  WB_rf_waddr_a,
    input  logic        WB_rf_we_b,
    input  logic        WB_long_b,
    input  logic [4:0]  WB_rf_waddr_b,
    output logic        issue_a,
    output logic        issue_b,
    output logic        ID_stall,
    output logic [31:0] busy
);

    logic [1:0] cnt_q [32];
    logic [1:0] cnt_d [32];

    logic haz_a, haz_b, dep_ab;
    logic inc_a, inc_b, dec_wb_a, dec_wb_b, kill_a, kill_b;
    logic same_dest_inc;
    logic [2:0] up, down, diff;

    always_comb begin
        haz_a = (ID_rf_re_a1 && ID_rf_raddr_a1 != 5'd0 && cnt_q[ID_rf_raddr_a1] != 2'd0) ||
                (ID_rf_re_a2 && ID_rf_raddr_a2 != 5'd0 && cnt_q[ID_rf_raddr_a2] != 2'd0) ||
                (ID_long_a && ID_rf_we_a && ID_rf_waddr_a != 5'd0 &&
                 cnt_q[ID_rf_waddr_a] == 2'd3);
        issue_a = ID_valid_a && EX_ready && !flush && !haz_a;
        inc_a   = issue_a && ID_rf_we_a && ID_long_a && ID_rf_waddr_a != 5'd0;

        // b's saturation check must account for a's increment to the same register
        same_dest_inc = inc_a && ID_rf_waddr_a == ID_rf_waddr_b;
        haz_b = (ID_rf_re_b1 && ID_rf_raddr_b1 != 5'd0 && cnt_q[ID_rf_raddr_b1] != 2'd0) ||
                (ID_rf_re_b2 && ID_rf_raddr_b2 != 5'd0 && cnt_q[ID_rf_raddr_b2] != 2'd0) ||
                (ID_long_b && ID_rf_we_b && ID_rf_waddr_b != 5'd0 &&
                 ({1'b0, cnt_q[ID_rf_waddr_b]} + {2'b00, same_dest_inc}) >= 3'd3);
        dep_ab = ID_rf_we_a && ID_rf_waddr_a != 5'd0 &&
                 ((ID_rf_re_b1 && ID_rf_raddr_b1 == ID_rf_waddr_a) ||
                  (ID_rf_re_b2 && ID_rf_raddr_b2 == ID_rf_waddr_a));
        issue_b = issue_a && ID_valid_b && !haz_b && !dep_ab;
        inc_b   = issue_b && ID_rf_we_b && ID_long_b && ID_rf_waddr_b != 5'd0;

        dec_wb_a = WB_rf_we_a && WB_long_a && WB_rf_waddr_a != 5'd0;
        dec_wb_b = WB_rf_we_b && WB_long_b && WB_rf_waddr_b != 5'd0;
        kill_a   = flush && EX_valid_a && EX_rf_we_a && EX_long_a && EX_rf_waddr_a != 5'd0;
        kill_b   = flush && EX_valid_b && EX_rf_we_b && EX_long_b && EX_rf_waddr_b != 5'd0;

        ID_stall = (ID_valid_a && !issue_a) || (ID_valid_b && !issue_b);
    end

    // All same-cycle increments and decrements net out before clamping to 0..3
    always_comb begin
        up   = 3'd0;
        down = 3'd0;
        diff = 3'd0;
        busy = 32'd0;
        for (int r = 0; r < 32; r++) begin
            up   = {1'b0, cnt_q[r]} +
                   {2'b00, inc_a && ID_rf_waddr_a == 5'(r)} +
                   {2'b00, inc_b && ID_rf_waddr_b == 5'(r)};
            down = {2'b00, dec_wb_a && WB_rf_waddr_a == 5'(r)} +
                   {2'b00, dec_wb_b && WB_rf_waddr_b == 5'(r)} +
                   {2'b00, kill_a && EX_rf_waddr_a == 5'(r)} +
                   {2'b00, kill_b && EX_rf_waddr_b == 5'(r)};
            diff = up - down;
            if (r == 0 || up <= down) begin
                cnt_d[r] = 2'd0;
            end else if (diff > 3'd3) begin
                cnt_d[r] = 2'd3;
            end else begin
                cnt_d[r] = diff[1:0];
            end
            busy[r] = (r != 0) && (cnt_q[r] != 2'd0);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int r = 0; r < 32; r++) begin
                cnt_q[r] <= 2'd0;
            end
        end else begin
            for (int r = 0; r < 32; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed scenarios plus random
// traffic, all checked against an integer pending-writer model.
module tb_reg_scoreboard;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        ID_valid_a, ID_rf_re_a1, ID_rf_re_a2, ID_rf_we_a, ID_long_a;
    logic [4:0]  ID_rf_raddr_a1, ID_rf_raddr_a2, ID_rf_waddr_a;
    logic        ID_valid_b, ID_rf_re_b1, ID_rf_re_b2, ID_rf_we_b, ID_long_b;
    logic [4:0]  ID_rf_raddr_b1, ID_rf_raddr_b2, ID_rf_waddr_b;
    logic        EX_ready, flush;
    logic        EX_valid_a, EX_rf_we_a, EX_long_a, EX_valid_b, EX_rf_we_b, EX_long_b;
    logic [4:0]  EX_rf_waddr_a, EX_rf_waddr_b;
    logic        WB_rf_we_a, WB_long_a, WB_rf_we_b, WB_long_b;
    logic [4:0]  WB_rf_waddr_a, WB_rf_waddr_b;
    logic        issue_a, issue_b, ID_stall;
    logic [31:0] busy;

    int compared = 0;
    int mismatched = 0;
    int pend [32];

    reg_scoreboard dut (
        .clk(clk), .rstn(rstn),
        .ID_valid_a(ID_valid_a), .ID_rf_raddr_a1(ID_rf_raddr_a1), .ID_rf_raddr_a2(ID_rf_raddr_a2),
        .ID_rf_re_a1(ID_rf_re_a1), .ID_rf_re_a2(ID_rf_re_a2), .ID_rf_waddr_a(ID_rf_waddr_a),
        .ID_rf_we_a(ID_rf_we_a), .ID_long_a(ID_long_a),
        .ID_valid_b(ID_valid_b), .ID_rf_raddr_b1(ID_rf_raddr_b1), .ID_rf_raddr_b2(ID_rf_raddr_b2),
        .ID_rf_re_b1(ID_rf_re_b1), .ID_rf_re_b2(ID_rf_re_b2), .ID_rf_waddr_b(ID_rf_waddr_b),
        .ID_rf_we_b(ID_rf_we_b), .ID_long_b(ID_long_b),
        .EX_ready(EX_ready), .flush(flush),
        .EX_valid_a(EX_valid_a), .EX_rf_we_a(EX_rf_we_a), .EX_long_a(EX_long_a),
        .EX_rf_waddr_a(EX_rf_waddr_a),
        .EX_valid_b(EX_valid_b), .EX_rf_we_b(EX_rf_we_b), .EX_long_b(EX_long_b),
        .EX_rf_waddr_b(EX_rf_waddr_b),
        .WB_rf_we_a(WB_rf_we_a), .WB_long_a(WB_long_a), .WB_rf_waddr_a(WB_rf_waddr_a),
        .WB_rf_we_b(WB_rf_we_b), .WB_long_b(WB_long_b), .WB_rf_waddr_b(WB_rf_waddr_b),
        .issue_a(issue_a), .issue_b(issue_b), .ID_stall(ID_stall), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit srcWait(input logic [4:0] addr, input logic re);
        return re && addr != 5'd0 && pend[addr] > 0;
    endfunction

    task automatic clearInputs();
        {ID_valid_a, ID_rf_re_a1, ID_rf_re_a2, ID_rf_we_a, ID_long_a} = '0;
        {ID_rf_raddr_a1, ID_rf_raddr_a2, ID_rf_waddr_a} = '0;
        {ID_valid_b, ID_rf_re_b1, ID_rf_re_b2, ID_rf_we_b, ID_long_b} = '0;
        {ID_rf_raddr_b1, ID_rf_raddr_b2, ID_rf_waddr_b} = '0;
        EX_ready = 1'b1;
        flush = 1'b0;
        {EX_valid_a, EX_rf_we_a, EX_long_a, EX_valid_b, EX_rf_we_b, EX_long_b} = '0;
        {EX_rf_waddr_a, EX_rf_waddr_b} = '0;
        {WB_rf_we_a, WB_long_a, WB_rf_we_b, WB_long_b} = '0;
        {WB_rf_waddr_a, WB_rf_waddr_b} = '0;
    endtask

    task automatic setA(input logic v, input logic [4:0] r1, input logic e1, input logic [4:0] r2,
                        input logic e2, input logic [4:0] w, input logic we, input logic lg);
        ID_valid_a = v; ID_rf_raddr_a1 = r1; ID_rf_re_a1 = e1; ID_rf_raddr_a2 = r2;
        ID_rf_re_a2 = e2; ID_rf_waddr_a = w; ID_rf_we_a = we; ID_long_a = lg;
    endtask

    task automatic setB(input logic v, input logic [4:0] r1, input logic e1, input logic [4:0] r2,
                        input logic e2, input logic [4:0] w, input logic we, input logic lg);
        ID_valid_b = v; ID_rf_raddr_b1 = r1; ID_rf_re_b1 = e1; ID_rf_raddr_b2 = r2;
        ID_rf_re_b2 = e2; ID_rf_waddr_b = w; ID_rf_we_b = we; ID_long_b = lg;
    endtask

    // One clock of traffic: predict the issue decision from outstanding-writer
    // counts, compare, then apply every retirement/issue/kill event as a net delta.
    task automatic applyStimulus();
        bit hA, hB, dep, iA, iB;
        int aSame;
        int nxt [32];
        logic [31:0] expBusy;
        #2;
        hA = srcWait(ID_rf_raddr_a1, ID_rf_re_a1) || srcWait(ID_rf_raddr_a2, ID_rf_re_a2) ||
             (ID_long_a && ID_rf_we_a && ID_rf_waddr_a != 0 && pend[ID_rf_waddr_a] >= 3);
        iA = ID_valid_a && EX_ready && !flush && !hA;
        aSame = (iA && ID_long_a && ID_rf_we_a && ID_rf_waddr_a != 0 &&
                 ID_rf_waddr_a == ID_rf_waddr_b) ? 1 : 0;
        hB = srcWait(ID_rf_raddr_b1, ID_rf_re_b1) || srcWait(ID_rf_raddr_b2, ID_rf_re_b2) ||
             (ID_long_b && ID_rf_we_b && ID_rf_waddr_b != 0 && pend[ID_rf_waddr_b] + aSame + 1 > 3);
        dep = ID_rf_we_a && ID_rf_waddr_a != 0 &&
              ((ID_rf_re_b1 && ID_rf_raddr_b1 == ID_rf_waddr_a) ||
               (ID_rf_re_b2 && ID_rf_raddr_b2 == ID_rf_waddr_a));
        iB = iA && ID_valid_b && !hB && !dep;
        expBusy = '0;
        for (int r = 1; r < 32; r++) expBusy[r] = (pend[r] != 0);
        checkOutput("issue_a", {31'b0, issue_a}, {31'b0, iA});
        checkOutput("issue_b", {31'b0, issue_b}, {31'b0, iB});
        checkOutput("ID_stall", {31'b0, ID_stall},
                    {31'b0, (ID_valid_a && !iA) || (ID_valid_b && !iB)});
        checkOutput("busy", busy, expBusy);
        nxt = pend;
        if (iA && ID_rf_we_a && ID_long_a && ID_rf_waddr_a != 0) nxt[ID_rf_waddr_a]++;
        if (iB && ID_rf_we_b && ID_long_b && ID_rf_waddr_b != 0) nxt[ID_rf_waddr_b]++;
        if (WB_rf_we_a && WB_long_a && WB_rf_waddr_a != 0) nxt[WB_rf_waddr_a]--;
        if (WB_rf_we_b && WB_long_b && WB_rf_waddr_b != 0) nxt[WB_rf_waddr_b]--;
        if (flush && EX_valid_a && EX_rf_we_a && EX_long_a && EX_rf_waddr_a != 0) nxt[EX_rf_waddr_a]--;
        if (flush && EX_valid_b && EX_rf_we_b && EX_long_b && EX_rf_waddr_b != 0) nxt[EX_rf_waddr_b]--;
        for (int r = 0; r < 32; r++) begin
            if (nxt[r] < 0) nxt[r] = 0;
            if (nxt[r] > 3) nxt[r] = 3;
        end
        @(posedge clk);
        #1;
        pend = nxt;
    endtask

    initial begin
        for (int r = 0; r < 32; r++) pend[r] = 0;
        clearInputs();
        #3;
        $display("[TB] reset state");
        checkOutput("reset_busy", busy, 32'h0);
        setA(1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 1);
        #1;
        checkOutput("reset_issue_a", {31'b0, issue_a}, 32'd1);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        clearInputs();

        $display("[TB] load-use");
        setA(1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 1);
        applyStimulus();
        clearInputs();
        setA(1, 5'd5, 1, 5'd0, 0, 5'd8, 1, 0);
        #1;
        checkOutput("lu_busy5_set", {31'b0, busy[5]}, 32'd1);
        checkOutput("lu_issue_a_stall", {31'b0, issue_a}, 32'd0);
        checkOutput("lu_stall", {31'b0, ID_stall}, 32'd1);
        applyStimulus();
        WB_rf_we_a = 1; WB_long_a = 1; WB_rf_waddr_a = 5'd5;
        applyStimulus();
        WB_rf_we_a = 0; WB_long_a = 0; WB_rf_waddr_a = 5'd0;
        #1;
        checkOutput("lu_busy5_clear", {31'b0, busy[5]}, 32'd0);
        checkOutput("lu_issue_after_wb", {31'b0, issue_a}, 32'd1);
        applyStimulus();

        $display("[TB] intra-pair dependency");
        clearInputs();
        setA(1, 5'd0, 0, 5'd0, 0, 5'd3, 1, 0);
        setB(1, 5'd3, 1, 5'd0, 0, 5'd10, 1, 0);
        #1;
        checkOutput("dep_issue_a", {31'b0, issue_a}, 32'd1);
        checkOutput("dep_issue_b", {31'b0, issue_b}, 32'd0);
        applyStimulus();
        clearInputs();
        setA(1, 5'd3, 1, 5'd0, 0, 5'd10, 1, 0);
        #1;
        checkOutput("dep_b_as_a", {31'b0, issue_a}, 32'd1);
        applyStimulus();

        $display("[TB] same-edge update");
        clearInputs();
        setA(1, 5'd0, 0, 5'd0, 0, 5'd7, 1, 1);
        applyStimulus();
        WB_rf_we_a = 1; WB_long_a = 1; WB_rf_waddr_a = 5'd7;
        applyStimulus();
        clearInputs();
        #1;
        checkOutput("same_edge_busy7", {31'b0, busy[7]}, 32'd1);
        WB_rf_we_a = 1; WB_long_a = 1; WB_rf_waddr_a = 5'd7;
        applyStimulus();
        clearInputs();
        #1;
        checkOutput("same_edge_drain7", {31'b0, busy[7]}, 32'd0);

        $display("[TB] saturation");
        for (int i = 0; i < 3; i++) begin
            clearInputs();
            setA(1, 5'd0, 0, 5'd0, 0, 5'd9, 1, 1);
            applyStimulus();
        end
        #1;
        checkOutput("sat_fourth_blocked", {31'b0, issue_a}, 32'd0);
        applyStimulus();
        WB_rf_we_b = 1; WB_long_b = 1; WB_rf_waddr_b = 5'd9;
        applyStimulus();
        WB_rf_we_b = 0; WB_long_b = 0; WB_rf_waddr_b = 5'd0;
        #1;
        checkOutput("sat_fourth_issues", {31'b0, issue_a}, 32'd1);
        applyStimulus();
        clearInputs();
        for (int i = 0; i < 3; i++) begin
            WB_rf_we_a = 1; WB_long_a = 1; WB_rf_waddr_a = 5'd9;
            applyStimulus();
        end
        clearInputs();

        $display("[TB] flush kill");
        for (int i = 0; i < 2; i++) begin
            setA(1, 5'd0, 0, 5'd0, 0, 5'd4, 1, 1);
            applyStimulus();
        end
        clearInputs();
        setA(1, 5'd0, 0, 5'd0, 0, 5'd11, 1, 1);
        setB(1, 5'd0, 0, 5'd0, 0, 5'd12, 1, 0);
        flush = 1; EX_valid_a = 1; EX_rf_we_a = 1; EX_long_a = 1; EX_rf_waddr_a = 5'd4;
        #1;
        checkOutput("flush_issue_a", {31'b0, issue_a}, 32'd0);
        checkOutput("flush_issue_b", {31'b0, issue_b}, 32'd0);
        applyStimulus();
        clearInputs();
        #1;
        checkOutput("flush_busy4_kept", {31'b0, busy[4]}, 32'd1);
        WB_rf_we_a = 1; WB_long_a = 1; WB_rf_waddr_a = 5'd4;
        applyStimulus();
        clearInputs();
        #1;
        checkOutput("flush_busy4_drained", {31'b0, busy[4]}, 32'd0);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            setA($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 1'($urandom),
                 5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)),
                 1'($urandom), 1'($urandom));
            setB($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 1'($urandom),
                 5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)),
                 1'($urandom), 1'($urandom));
            EX_ready = $urandom_range(0, 7) != 0;
            flush = $urandom_range(0, 9) == 0;
            EX_valid_a = 1'($urandom); EX_rf_we_a = 1'($urandom); EX_long_a = 1'($urandom);
            EX_rf_waddr_a = 5'($urandom_range(0, 7));
            EX_valid_b = 1'($urandom); EX_rf_we_b = 1'($urandom); EX_long_b = 1'($urandom);
            EX_rf_waddr_b = 5'($urandom_range(0, 7));
            WB_rf_we_a = $urandom_range(0, 2) == 0; WB_long_a = 1'($urandom);
            WB_rf_waddr_a = 5'($urandom_range(0, 7));
            WB_rf_we_b = $urandom_range(0, 2) == 0; WB_long_b = 1'($urandom);
            WB_rf_waddr_b = 5'($urandom_range(0, 7));
            applyStimulus();
        end

        $display("[TB] reset mid-flight");
        clearInputs();
        for (int r = 1; r < 32; r++) begin
            for (int k = 0; k < 3; k++) begin
                if (pend[r] > 0) begin
                    WB_rf_we_a = 1; WB_long_a = 1; WB_rf_waddr_a = 5'(r);
                    applyStimulus();
                end
            end
        end
        clearInputs();
        setA(1, 5'd0, 0, 5'd0, 0, 5'd4, 1, 1);
        setB(1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 1);
        applyStimulus();
        clearInputs();
        setA(1, 5'd0, 0, 5'd0, 0, 5'd9, 1, 1);
        applyStimulus();
        clearInputs();
        checkOutput("pre_reset_busy", busy, 32'h0000_0230);
        #1;
        rstn = 1'b0;
        #1;
        checkOutput("mid_reset_busy", busy, 32'h0);
        for (int r = 0; r < 32; r++) pend[r] = 0;
        setA(1, 5'd0, 1, 5'd0, 1, 5'd0, 1, 1);
        setB(1, 5'd0, 1, 5'd0, 1, 5'd0, 1, 1);
        #1;
        checkOutput("r0_issue_a", {31'b0, issue_a}, 32'd1);
        checkOutput("r0_issue_b", {31'b0, issue_b}, 32'd1);
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus();
        clearInputs();
        #1;
        checkOutput("r0_never_busy", busy, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
